// File: rtl/sm_drain.sv
// Captures one sorted frame by rank into a buffer, then streams it out with valid/ready.
// Optional SM_DRAIN_ORDER_CHECK_EN adds an ascending-order check on captured data.
module sm_drain #(
    parameter int DATA_WIDTH       = 8,
    parameter int ELEMENT_NUM      = 16,
    parameter int LOG2_ELEMENT_NUM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sm_valid,
    input  logic [LOG2_ELEMENT_NUM-1:0] sm_addr,
    input  logic [DATA_WIDTH-1:0]       sm_data,
    input  logic                        clr_err,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        addr_err,
    output logic                        overrun,
    output logic                        order_err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [LOG2_ELEMENT_NUM-1:0] LAST = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

    state_t                      r_state;
    logic [LOG2_ELEMENT_NUM:0]   r_cnt;
    logic [LOG2_ELEMENT_NUM-1:0] r_rd_ptr;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic                        r_busy;
    logic                        r_addr_err;
    logic                        r_overrun;
    logic [DATA_WIDTH-1:0]       r_buf [ELEMENT_NUM];

    logic                        w_wr;
    logic                        w_addr_set;
    logic                        w_ovr_set;
    logic [LOG2_ELEMENT_NUM-1:0] w_rd_nxt;

    // A bad first rank in IDLE writes nothing; out-of-sequence ranks in CAPTURE still write.
    assign w_wr = !rst && sm_valid &&
                  ((r_state == IDLE && sm_addr == '0) || r_state == CAPTURE);
    assign w_addr_set = sm_valid &&
                        ((r_state == IDLE && sm_addr != '0) ||
                         (r_state == CAPTURE && {1'b0, sm_addr} != r_cnt));
    assign w_ovr_set  = sm_valid && r_state == DRAIN;
    assign w_rd_nxt   = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr) r_buf[sm_addr] <= sm_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Set wins over a simultaneous clear.
            r_addr_err <= w_addr_set | (r_addr_err & ~clr_err);
            r_overrun  <= w_ovr_set  | (r_overrun  & ~clr_err);
            case (r_state)
                IDLE: begin
                    if (sm_valid && sm_addr == '0) begin
                        r_cnt   <= 1;
                        r_state <= CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (sm_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (sm_addr == LAST) begin
                            r_state     <= DRAIN;
                            r_rd_ptr    <= '0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (LAST == '0);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_ptr == LAST) begin
                            r_state     <= IDLE;
                            r_cnt       <= '0;
                            r_rd_ptr    <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_rd_ptr   <= w_rd_nxt;
                            r_out_last <= (w_rd_nxt == LAST);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SM_DRAIN_ORDER_CHECK_EN
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_order_err;
    logic                  w_ord_set;

    assign w_ord_set = sm_valid && r_state == CAPTURE && sm_addr != '0 && sm_data < r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= '0;
            r_order_err <= 1'b0;
        end else begin
            if (w_wr) r_prev <= sm_data;
            r_order_err <= w_ord_set | (r_order_err & ~clr_err);
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_buf[r_rd_ptr];
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign addr_err  = r_addr_err;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_sm_drain.sv
// Directed bench for sm_drain: capture/drain, backpressure, error flags, mid-frame reset.
module tb_sm_drain;
    logic       clk = 1'b0;
    logic       rst, sm_valid, clr_err, out_ready;
    logic [3:0] sm_addr;
    logic [7:0] sm_data;
    logic       out_valid, out_last, busy, addr_err, overrun, order_err;
    logic [7:0] out_data;

    logic [7:0] frame [16];
    int n_tests = 0;
    int n_fail  = 0;
`ifdef SM_DRAIN_ORDER_CHECK_EN
    localparam logic ORD_EXP = 1'b1;
`else
    localparam logic ORD_EXP = 1'b0;
`endif

    sm_drain #(.DATA_WIDTH(8), .ELEMENT_NUM(16), .LOG2_ELEMENT_NUM(4)) dut (
        .clk(clk), .rst(rst), .sm_valid(sm_valid), .sm_addr(sm_addr), .sm_data(sm_data),
        .clr_err(clr_err), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .busy(busy), .addr_err(addr_err), .overrun(overrun),
        .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Presents n elements; swap exchanges the ranks of elements 1 and 2.
    task automatic send_frame(input int n, input bit swap);
        int a;
        for (int i = 0; i < n; i++) begin
            a = (swap && i == 1) ? 2 : (swap && i == 2) ? 1 : i;
            sm_valid = 1'b1;
            sm_addr  = 4'(a);
            sm_data  = frame[a];
            @(negedge clk);
            chk("cap_busy", busy, 1);
            if (i < 15) chk("cap_valid", out_valid, 0);
        end
        sm_valid = 1'b0;
        if (n == 16) chk("first_valid", out_valid, 1);
    endtask

    // Drains up to `stop` elements; toggle applies ready pattern 1,0,1,0...
    task automatic drain_frame(input bit toggle, input int stop);
        int  idx = 0;
        int  cyc = 0;
        logic rdy;
        while (idx < stop && cyc < 100) begin
            chk("drn_valid", out_valid, 1);
            chk("drn_data", out_data, frame[idx]);
            chk("drn_last", out_last, (idx == 15) ? 1 : 0);
            rdy = toggle ? ~cyc[0] : 1'b1;
            out_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        chk("drn_count", idx, stop);
        out_ready = 1'b1;
        if (stop == 16) begin
            chk("end_valid", out_valid, 0);
            chk("end_busy", busy, 0);
        end
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_addr", addr_err, 0);
        chk("clr_ovr", overrun, 0);
        chk("clr_ord", order_err, 0);
    endtask

    initial begin
        rst = 1'b1; sm_valid = 1'b0; sm_addr = '0; sm_data = '0;
        clr_err = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ord", order_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ascending frame, ready held high.
        for (int i = 0; i < 16; i++) frame[i] = 8'(i);
        send_frame(16, 0);
        drain_frame(0, 16);
        chk("asc_addr", addr_err, 0);

        // Backpressure 1,0,1,0.
        for (int i = 0; i < 16; i++) frame[i] = 8'(8'h10 + 3 * i);
        send_frame(16, 0);
        drain_frame(1, 16);

        // Bad rank in IDLE, then clear, then set+clear together.
        sm_valid = 1'b1; sm_addr = 4'd3; sm_data = 8'h55;
        @(negedge clk);
        sm_valid = 1'b0;
        chk("idle_addr_err", addr_err, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        clear_errs();
        sm_valid = 1'b1; clr_err = 1'b1;
        @(negedge clk);
        sm_valid = 1'b0; clr_err = 1'b0;
        chk("set_wins", addr_err, 1);
        clear_errs();

        // Out-of-sequence ranks in CAPTURE still land in the buffer.
        for (int i = 0; i < 16; i++) frame[i] = 8'(8'h80 + i);
        send_frame(16, 1);
        chk("cap_addr_err", addr_err, 1);
        drain_frame(0, 16);
        clear_errs();

        // Overrun during DRAIN leaves the buffer intact.
        for (int i = 0; i < 16; i++) frame[i] = 8'(8'hF0 - i);
        send_frame(16, 0);
        out_ready = 1'b0; sm_valid = 1'b1; sm_addr = 4'd0; sm_data = 8'hAA;
        @(negedge clk);
        sm_valid = 1'b0;
        chk("overrun", overrun, 1);
        drain_frame(0, 16);
        clear_errs();

        // Descending pair at ranks 4/5.
        for (int i = 0; i < 16; i++) frame[i] = 8'(i);
        frame[4] = 8'd5; frame[5] = 8'd3;
        send_frame(16, 0);
        chk("order_err", order_err, ORD_EXP);
        chk("order_addr", addr_err, 0);
        drain_frame(0, 16);
        clear_errs();

        // Reset mid-CAPTURE abandons the frame.
        send_frame(5, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstc_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("rstc_valid", out_valid, 0);

        // Reset at the 8th element of DRAIN, then a fresh frame.
        for (int i = 0; i < 16; i++) frame[i] = 8'(8'h40 + 2 * i);
        send_frame(16, 0);
        drain_frame(0, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstd_valid", out_valid, 0);
        chk("rstd_busy", busy, 0);
        chk("rstd_last", out_last, 0);
        repeat (3) @(negedge clk);
        chk("rstd_idle", out_valid, 0);
        for (int i = 0; i < 16; i++) frame[i] = 8'(8'hC0 + i);
        send_frame(16, 0);
        drain_frame(0, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sm_drain.md
SM_DRAIN -- requirements
Module: sm_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one sorted element.
REQ-002 SHALL have parameter ELEMENT_NUM, default 16, elements per sorted frame.
REQ-003 SHALL have parameter LOG2_ELEMENT_NUM, default 4, equal to log2(ELEMENT_NUM).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port sm_valid, input, 1, sorted element present this cycle.
REQ-007 SHALL have port sm_addr, input, LOG2_ELEMENT_NUM, rank of the presented element.
REQ-008 SHALL have port sm_data, input, DATA_WIDTH, sorted element value.
REQ-009 SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts an element.
REQ-011 SHALL have port out_valid, output, 1, out_data is valid.
REQ-012 SHALL have port out_data, output, DATA_WIDTH, streamed element.
REQ-013 SHALL have port out_last, output, 1, final element of the frame.
REQ-014 SHALL have port busy, output, 1, high in CAPTURE or DRAIN.
REQ-015 SHALL have ports addr_err, overrun and order_err, output, 1 each, sticky error flags.

Function
REQ-016 SHALL implement three states: IDLE, CAPTURE and DRAIN, with an ELEMENT_NUM x DATA_WIDTH buffer, a capture counter cnt and a read pointer rd_ptr.
REQ-017 In IDLE, sm_valid with sm_addr==0 SHALL write buf[0], set cnt=1 and enter CAPTURE.
REQ-018 In IDLE, sm_valid with sm_addr!=0 SHALL set addr_err, write nothing and stay in IDLE.
REQ-019 In CAPTURE, each sm_valid SHALL write buf[sm_addr] and increment cnt; sm_addr!=cnt SHALL set addr_err, and the write still goes to sm_addr.
REQ-020 In CAPTURE, a write with sm_addr==ELEMENT_NUM-1 SHALL enter DRAIN on the next cycle with rd_ptr=0, regardless of cnt.
REQ-021 Cycles in CAPTURE without sm_valid SHALL hold state; there is no timeout.
REQ-022 In DRAIN: out_valid=1, out_data=buf[rd_ptr] (combinational from registered buffer), and out_last=(rd_ptr==ELEMENT_NUM-1).
REQ-023 A transfer occurs when out_valid and out_ready are both high; it SHALL increment rd_ptr.
REQ-024 The transfer of the last element SHALL return the block to IDLE with cnt=0 and rd_ptr=0.
REQ-025 While out_ready is low, out_data and out_last SHALL hold stable.
REQ-026 sm_valid during DRAIN SHALL set overrun; the data is dropped and the buffer is unchanged.
REQ-027 out_valid SHALL be 0 in IDLE and CAPTURE.
REQ-028 The first out_valid SHALL occur exactly 1 cycle after the cycle of the last capture write.
REQ-029 Sticky flags SHALL be cleared by clr_err on the next edge; simultaneous set and clr_err SHALL leave the flag set.
REQ-030 busy SHALL be registered from the state and SHALL equal (state!=IDLE).

Reset
REQ-031 rst SHALL force state IDLE, with cnt, rd_ptr, out_valid, out_last, busy, addr_err, overrun and order_err all at 0.
REQ-032 Buffer contents SHALL NOT be reset.
REQ-033 rst asserted mid-CAPTURE or mid-DRAIN SHALL abandon the frame; no further out_valid occurs until a new frame completes.
REQ-034 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-035 Macro SM_DRAIN_ORDER_CHECK_EN defined: in CAPTURE, for a write with sm_addr>0, sm_data less than the previous captured value (unsigned) SHALL set order_err; the previous value is held in a DATA_WIDTH register reset to 0.
REQ-036 Macro SM_DRAIN_ORDER_CHECK_EN undefined: order_err SHALL be constant 0, and no comparator or previous-value register is built.

Verification
REQ-037 Ascending frame 0..15 presented at sm_addr 0..15 on consecutive cycles, with out_ready=1: out_valid rises 1 cycle after addr 15; outputs are 0..15 over 16 cycles; out_last is high only on 15; then back to IDLE and busy=0.
REQ-038 Same frame with out_ready toggled 1,0,1,0: each element is held while out_ready=0; all 16 values are delivered in order with no duplicates.
REQ-039 sm_valid with sm_addr=3 in IDLE: addr_err=1, busy stays 0; clr_err pulse: addr_err=0.
REQ-040 sm_valid pulse during DRAIN (sm_data=0xAA, sm_addr=0): overrun=1, and the stream still emits the original frame unchanged.
REQ-041 With the macro defined, a frame containing 5 at addr 4 followed by 3 at addr 5: order_err=1; with the macro undefined, order_err=0 for the same stimulus.
REQ-042 rst asserted at the 8th element of DRAIN: out_valid=0 on the next cycle; a new full frame is then streamed correctly.
